// File: rtl/fetch_decode_buffer.sv
// Fetch-to-decode skid FIFO. Holds {PC, instruction} pairs so fetch can run
// ahead of a stalled decode stage. A taken-branch flush empties it, the head
// reads as a NOP when empty, and decode-side bubbles are counted.
module fetch_decode_buffer #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h00000013,
    parameter int          CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     if_valid,
    output logic                     if_ready,
    input  logic [31:0]              if_pc,
    input  logic [31:0]              if_instr,
    input  logic                     flush,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [31:0]              id_pc,
    output logic [31:0]              id_instr,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         bubble_count
);

    localparam int             AW   = $clog2(DEPTH);
    localparam logic [AW:0]    FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fd_entry_t;

    fd_entry_t       mem [DEPTH];
    fd_entry_t       head;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic            push, pop;

    // Ready comes from the registered count only: a full buffer cannot
    // accept even when decode drains it in the same cycle.
    assign if_ready = (count != FULL);
    assign id_valid = (count != '0);
    assign push     = if_valid & if_ready & ~flush;
    assign pop      = id_valid & id_ready & ~flush;

    // Head is shown straight from storage; empty buffer reads as a NOP at PC 0.
    assign head     = mem[rd_ptr];
    assign id_pc    = id_valid ? head.pc    : '0;
    assign id_instr = id_valid ? head.instr : NOP_INSTR;

    // Pointers and occupancy; flush overrides any same-cycle push or pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{pc: if_pc, instr: if_instr};
    end

    // Saturating count of cycles where decode wanted work and none was there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bubble_count <= '0;
        else if (id_ready && !id_valid && !flush && (bubble_count != '1))
            bubble_count <= bubble_count + 1'b1;
    end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed bench for fetch_decode_buffer: a queue model checked every cycle,
// plus literal expectations for each scenario. A second instance with a
// 4-bit bubble counter shares the stimulus to exercise saturation.
module tb_fetch_decode_buffer;

    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_valid = 1'b0, flush = 1'b0, id_ready = 1'b0;
    logic [31:0] if_pc = '0, if_instr = '0;

    logic        if_ready, id_valid;
    logic [31:0] id_pc, id_instr;
    logic [1:0]  count;
    logic [15:0] bubble_count;

    logic        if_ready4, id_valid4;
    logic [31:0] id_pc4, id_instr4;
    logic [1:0]  count4;
    logic [3:0]  bubble4;

    int checks = 0;
    int errors = 0;

    fetch_decode_buffer #(.DEPTH(DEPTH), .NOP_INSTR(NOP), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(if_ready),
        .if_pc(if_pc), .if_instr(if_instr), .flush(flush), .id_valid(id_valid),
        .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr), .count(count),
        .bubble_count(bubble_count)
    );

    fetch_decode_buffer #(.DEPTH(DEPTH), .NOP_INSTR(NOP), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(if_ready4),
        .if_pc(if_pc), .if_instr(if_instr), .flush(flush), .id_valid(id_valid4),
        .id_ready(id_ready), .id_pc(id_pc4), .id_instr(id_instr4), .count(count4),
        .bubble_count(bubble4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural model: an ordered queue of {pc, instr} plus bubble tallies.
    logic [63:0] mq[$];
    int unsigned mb16 = 0;
    int unsigned mb4  = 0;

    // Model update from the rules: accept when not full, drain when not
    // empty, flush discards everything, bubbles counted while empty.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            mb16 <= 0;
            mb4  <= 0;
        end else begin
            if (id_ready && mq.size() == 0 && !flush) begin
                if (mb16 < 65535) mb16 <= mb16 + 1;
                if (mb4 < 15)     mb4  <= mb4 + 1;
            end
            if (flush)
                mq.delete();
            else if (mq.size() != 0 && id_ready) begin
                void'(mq.pop_front());
                if (if_valid && mq.size() + 1 != DEPTH) mq.push_back({if_pc, if_instr});
            end else if (if_valid && mq.size() != DEPTH)
                mq.push_back({if_pc, if_instr});
        end
    end

    // Entries the DUT actually handed to decode, in order.
    logic [63:0] dlog[$];

    // Per-cycle compare against the model, sampled away from the clock edge.
    always @(negedge clk) begin
        chk("id_valid", 64'(id_valid), 64'(mq.size() != 0));
        chk("if_ready", 64'(if_ready), 64'(mq.size() != DEPTH));
        chk("count", 64'(count), 64'(mq.size()));
        chk("id_pc", 64'(id_pc), (mq.size() != 0) ? 64'(mq[0][63:32]) : 64'd0);
        chk("id_instr", 64'(id_instr), (mq.size() != 0) ? 64'(mq[0][31:0]) : 64'(NOP));
        chk("bubble16", 64'(bubble_count), 64'(mb16));
        chk("bubble4", 64'(bubble4), 64'(mb4));
        if (!reset && id_valid && id_ready && !flush) dlog.push_back({id_pc, id_instr});
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Fetch side: present a pair and hold it until accepted (bounded).
    task automatic send(input logic [31:0] pc, input logic [31:0] ins);
        logic acc;
        acc = 1'b0;
        if_valid = 1'b1;
        if_pc    = pc;
        if_instr = ins;
        for (int n = 0; n < 50 && !acc; n++) begin
            acc = if_ready;
            cyc();
        end
        if_valid = 1'b0;
        if (!acc) chk("send_timeout", 64'(pc), 64'hFFFF_FFFF);
    endtask

    task automatic chk_seq(input string nm, input int n, input logic [31:0] base);
        chk({nm, "_len"}, 64'(dlog.size()), 64'(n));
        for (int i = 0; i < n && i < dlog.size(); i++)
            chk({nm, "_pc"}, 64'(dlog[i][63:32]), 64'(base + 32'(4 * i)));
    endtask

    initial begin
        // T1 reset
        repeat (2) cyc();
        chk("t1_id_valid", 64'(id_valid), 64'd0);
        chk("t1_id_instr", 64'(id_instr), 64'h13);
        chk("t1_if_ready", 64'(if_ready), 64'd1);
        chk("t1_count", 64'(count), 64'd0);
        chk("t1_bubble", 64'(bubble_count), 64'd0);
        reset = 1'b0;
        cyc();

        // T2 passthrough
        dlog.delete();
        id_ready = 1'b1;
        send(32'h0, 32'hA0);
        chk("t2_first_pc", 64'(id_pc), 64'h0);
        send(32'h4, 32'hA1);
        send(32'h8, 32'hA2);
        chk("t2_count", 64'(count), 64'd1);
        repeat (2) cyc();
        chk_seq("t2", 3, 32'h0);
        chk("t2_instr0", 64'(dlog[0][31:0]), 64'hA0);
        chk("t2_instr2", 64'(dlog[2][31:0]), 64'hA2);

        // T3 stall until full, then release
        dlog.delete();
        id_ready = 1'b0;
        send(32'h10, 32'hC0DE0010);
        send(32'h14, 32'hC0DE0014);
        chk("t3_full_count", 64'(count), 64'd2);
        chk("t3_full_ready", 64'(if_ready), 64'd0);
        if_valid = 1'b1;
        if_pc    = 32'h18;
        if_instr = 32'hC0DE0018;
        repeat (2) cyc();
        chk("t3_hold_pc", 64'(id_pc), 64'h10);
        chk("t3_hold_ready", 64'(if_ready), 64'd0);
        id_ready = 1'b1;
        send(32'h18, 32'hC0DE0018);
        repeat (3) cyc();
        chk_seq("t3", 3, 32'h10);

        // T4 flush while full with an incoming pair
        id_ready = 1'b0;
        send(32'h20, 32'hC0DE0020);
        send(32'h24, 32'hC0DE0024);
        chk("t4_pre_count", 64'(count), 64'd2);
        flush    = 1'b1;
        if_valid = 1'b1;
        if_pc    = 32'h40;
        if_instr = 32'hC0DE0040;
        cyc();
        flush    = 1'b0;
        if_valid = 1'b0;
        chk("t4_count", 64'(count), 64'd0);
        chk("t4_id_valid", 64'(id_valid), 64'd0);
        chk("t4_if_ready", 64'(if_ready), 64'd1);
        chk("t4_id_instr", 64'(id_instr), 64'h13);
        dlog.delete();
        id_ready = 1'b1;
        send(32'h80, 32'hC0DE0080);
        repeat (2) cyc();
        chk_seq("t4", 1, 32'h80);

        // T5 pointer wrap with alternating decode readiness
        dlog.delete();
        for (int i = 0; i < 10; i++) begin
            id_ready = i[0];
            send(32'h100 + 32'(4 * i), 32'hBEEF0000 + 32'(i));
        end
        id_ready = 1'b1;
        repeat (4) cyc();
        chk_seq("t5", 10, 32'h100);

        // T6 bubbles, saturation, async reset
        reset    = 1'b1;
        id_ready = 1'b0;
        repeat (2) cyc();
        reset    = 1'b0;
        id_ready = 1'b1;
        repeat (5) cyc();
        chk("t6_bubble5", 64'(bubble_count), 64'd5);
        chk("t6_bubble4_5", 64'(bubble4), 64'd5);
        repeat (20) cyc();
        chk("t6_bubble4_sat", 64'(bubble4), 64'd15);
        chk("t6_bubble16", 64'(bubble_count), 64'd25);
        id_ready = 1'b0;
        send(32'h200, 32'hC0DE0200);
        send(32'h204, 32'hC0DE0204);
        chk("t6_pre_count", 64'(count), 64'd2);
        #3;
        reset = 1'b1;
        #1;
        chk("t6_async_valid", 64'(id_valid), 64'd0);
        chk("t6_async_count", 64'(count), 64'd0);
        chk("t6_async_ready", 64'(if_ready), 64'd1);
        chk("t6_async_instr", 64'(id_instr), 64'h13);
        chk("t6_async_pc", 64'(id_pc), 64'd0);
        chk("t6_async_bubble", 64'(bubble_count), 64'd0);
        chk("t6_async_bubble4", 64'(bubble4), 64'd0);
        repeat (2) cyc();
        reset = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
